// File: rtl/logicnets_pkg.sv
// Shared definitions for the LogicNets front-end: packer FSM states, default
// frame geometry and the index-width helper used by the packer and the layer-0 wrapper.
package logicnets_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int DEF_NUM_FEATURES = 32;
    localparam int DEF_IN_WIDTH     = 16;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/feature_threshold_bank.sv
// Per-feature signed threshold register file with a write port and one
// indexed compare. A write lands on the clock edge, so a compare at the
// same index in the same cycle still sees the previous threshold.
module feature_threshold_bank
    import logicnets_pkg::*;
#(
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int IN_WIDTH     = DEF_IN_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_we,
    input  logic [idx_width(NUM_FEATURES)-1:0]   cfg_addr,
    input  logic signed [IN_WIDTH-1:0]           cfg_data,
    input  logic [idx_width(NUM_FEATURES)-1:0]   idx,
    input  logic signed [IN_WIDTH-1:0]           sample,
    output logic                                 hit
);

    logic signed [IN_WIDTH-1:0] thr [NUM_FEATURES];
    logic                       addr_ok;

    // Addresses past the last feature are silently dropped.
    assign addr_ok = (32'(cfg_addr) < NUM_FEATURES);

    // Threshold storage; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                thr[i] <= '0;
            end
        end else if (cfg_we && addr_ok) begin
            thr[cfg_addr] <= cfg_data;
        end
    end

    // Signed binarisation of the current beat.
    assign hit = (sample >= thr[idx]);

endmodule

// File: rtl/logicnets_feature_packer.sv
// Binarises a stream of signed features against per-feature thresholds and
// packs each frame into a NUM_FEATURES-bit vector for the layer-0 LUTs.
// The shift vector and output register form a double buffer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | accepting features of the current frame
// HOLD    | frame complete, output register still occupied; input stalled
// DISCARD | frame overran without s_last; dropping beats until s_last
module logicnets_feature_packer
    import logicnets_pkg::*;
#(
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int IN_WIDTH     = DEF_IN_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic signed [IN_WIDTH-1:0]           s_data,
    input  logic                                 s_last,
    input  logic                                 cfg_we,
    input  logic [idx_width(NUM_FEATURES)-1:0]   cfg_addr,
    input  logic signed [IN_WIDTH-1:0]           cfg_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [NUM_FEATURES-1:0]              m_data,
    output logic                                 frame_err,
    output logic [CNT_WIDTH-1:0]                 frame_cnt,
    output logic [CNT_WIDTH-1:0]                 err_cnt
);

    localparam int                 AW   = idx_width(NUM_FEATURES);
    localparam logic [AW-1:0]      LAST = AW'(NUM_FEATURES - 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [NUM_FEATURES-1:0] shift_q, shift_d;
    logic [NUM_FEATURES-1:0] vec_next;
    logic [NUM_FEATURES-1:0] load_vec;
    logic                    load;
    logic                    err;
    logic                    accept;
    logic                    drain;
    logic                    thr_hit;

    feature_threshold_bank #(
        .NUM_FEATURES (NUM_FEATURES),
        .IN_WIDTH     (IN_WIDTH)
    ) u_thr (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .idx      (idx_q),
        .sample   (s_data),
        .hit      (thr_hit)
    );

    // s_ready decodes registered state only, so m_ready never reaches it.
    assign s_ready = (state_q != HOLD);
    assign accept  = s_valid & s_ready;
    assign drain   = m_valid & m_ready;

    // Shift vector with the current beat's bit merged in.
    always_comb begin
        vec_next         = shift_q;
        vec_next[idx_q]  = thr_hit;
    end

    // Next-state, index and output-load decisions.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        load     = 1'b0;
        load_vec = shift_q;
        err      = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    shift_d = vec_next;
                    if (idx_q == LAST) begin
                        if (s_last) begin
                            if (!m_valid || drain) begin
                                load     = 1'b1;
                                load_vec = vec_next;
                                idx_d    = '0;
                            end else begin
                                state_d = HOLD;
                            end
                        end else begin
                            err     = 1'b1;
                            idx_d   = '0;
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        err   = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    load     = 1'b1;
                    load_vec = shift_q;
                    idx_d    = '0;
                    state_d  = COLLECT;
                end
            end
            DISCARD: begin
                if (accept && s_last) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = COLLECT;
            end
        endcase
    end

    // FSM, index and shift-vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Output register: a new frame may replace the old one on its handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_vec;
        end else if (drain) begin
            m_valid <= 1'b0;
        end
    end

    // Error pulse and saturating frame/error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            frame_err <= err;
            if (drain && (frame_cnt != '1)) begin
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
            if (err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_logicnets_feature_packer.sv
// Self-checking bench for logicnets_feature_packer. Expected vectors come from
// a plain array model: bit i = (feature i >= threshold i), signed.
// Counters are 3 bits wide here so saturation is reachable quickly.
module tb_logicnets_feature_packer;

    localparam int NF = 32;
    localparam int IW = 16;
    localparam int CW = 3;
    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [IW-1:0] s_data;
    logic                 s_last;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic signed [IW-1:0] cfg_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [NF-1:0]        m_data;
    logic                 frame_err;
    logic [CW-1:0]        frame_cnt;
    logic [CW-1:0]        err_cnt;

    logic signed [IW-1:0] fbuf [64];
    logic signed [IW-1:0] mthr [NF];
    logic [NF-1:0]        got_q [$];
    int                   err_pulses = 0;
    int                   checks = 0;
    int                   errors = 0;

    always #5 clk = ~clk;

    logicnets_feature_packer #(
        .NUM_FEATURES (NF),
        .IN_WIDTH     (IW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    // Observe delivered vectors and error pulses.
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (frame_err) err_pulses++;
        end
    end

    function automatic logic [NF-1:0] model_vec();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = (int'(fbuf[i]) >= int'(mthr[i]));
        return v;
    endfunction

    function automatic logic [CW-1:0] sat(input int n);
        return (n >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n);
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        cfg_we  = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        m_ready = 1'b0;
        for (int i = 0; i < NF; i++) mthr[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = IW'(v);
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        mthr[a]  = IW'(v);
    endtask

    task automatic send_beat(input logic signed [IW-1:0] d, input logic l);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: s_ready=%0b, required 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) send_beat(fbuf[i], (i == last_at));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) fbuf[i] = IW'(int'($urandom_range(0, 80)) - 40);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b, required 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b, required 1", s_ready); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b, required 0", frame_err); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); end
    endtask

    task automatic test_alternating();
        logic [NF-1:0] exp;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < NF; i++) fbuf[i] = (i % 2 == 0) ? IW'(5) : IW'(-5);
        exp = model_vec();
        send_frame(NF, NF - 1);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL alt_latency: m_valid=%0b, required 1", m_valid); end
        checks++; if (m_data !== 32'h5555_5555) begin errors++; $display("FAIL alt_data: got %h, required 55555555", m_data); end
        checks++; if (m_data !== exp) begin errors++; $display("FAIL alt_model: got %h, required %h", m_data, exp); end
        @(posedge clk); #1;
        checks++; if (frame_cnt !== sat(1)) begin errors++; $display("FAIL alt_frame_cnt: got %0d, required 1", frame_cnt); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL alt_drained: m_valid=%0b, required 0", m_valid); end
    endtask

    task automatic test_threshold();
        logic [NF-1:0] exp;
        do_reset();
        m_ready = 1'b1;
        cfg_write(3, 100);
        for (int i = 0; i < NF; i++) fbuf[i] = IW'(-1);
        fbuf[3] = IW'(100);
        exp = model_vec();
        send_frame(NF, NF - 1);
        checks++; if (m_data !== exp || m_valid !== 1'b1) begin errors++; $display("FAIL thr_equal: got %h v=%0b, required %h", m_data, m_valid, exp); end
        fbuf[3] = IW'(99);
        exp = model_vec();
        send_frame(NF, NF - 1);
        checks++; if (m_data !== exp || m_valid !== 1'b1) begin errors++; $display("FAIL thr_below: got %h v=%0b, required %h", m_data, m_valid, exp); end
    endtask

    task automatic test_random();
        logic [NF-1:0] exp_q [$];
        int base;
        bit done = 1'b0;
        do_reset();
        for (int a = 0; a < NF; a++) cfg_write(a, int'($urandom_range(0, 64)) - 32);
        base = got_q.size();
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    fill_random(NF);
                    exp_q.push_back(model_vec());
                    send_frame(NF, NF - 1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (got_q.size() - base != 6) begin errors++; $display("FAIL rand_count: got %0d, required 6", got_q.size() - base); end
        for (int k = 0; k < 6 && base + k < got_q.size(); k++) begin
            checks++;
            if (got_q[base + k] !== exp_q[k]) begin errors++; $display("FAIL rand_vec%0d: got %h, required %h", k, got_q[base + k], exp_q[k]); end
        end
        checks++; if (frame_cnt !== sat(6)) begin errors++; $display("FAIL rand_frame_cnt: got %0d, required %0d", frame_cnt, sat(6)); end
    endtask

    task automatic test_backpressure();
        logic [NF-1:0] exp_a, exp_b;
        do_reset();
        m_ready = 1'b0;
        fill_random(NF); exp_a = model_vec(); send_frame(NF, NF - 1);
        fill_random(NF); exp_b = model_vec(); send_frame(NF, NF - 1);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_low: got %0b, required 0", s_ready); end
        checks++; if (m_data !== exp_a || m_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got %h v=%0b, required %h", m_data, m_valid, exp_a); end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++; if (m_data !== exp_b || m_valid !== 1'b1) begin errors++; $display("FAIL bp_second: got %h v=%0b, required %h", m_data, m_valid, exp_b); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready_back: got %0b, required 1", s_ready); end
        checks++; if (frame_cnt !== sat(1)) begin errors++; $display("FAIL bp_frame_cnt: got %0d, required 1", frame_cnt); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_data !== exp_b || m_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h v=%0b, required %h", m_data, m_valid, exp_b); end
    endtask

    task automatic test_short_frame();
        logic [NF-1:0] exp;
        int b_out, b_err;
        do_reset();
        m_ready = 1'b1;
        b_out = got_q.size();
        b_err = err_pulses;
        fill_random(11);
        send_frame(11, 10);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err_pulses - b_err != 1) begin errors++; $display("FAIL short_pulses: got %0d, required 1", err_pulses - b_err); end
        checks++; if (err_cnt !== sat(1)) begin errors++; $display("FAIL short_err_cnt: got %0d, required 1", err_cnt); end
        checks++; if (got_q.size() != b_out || m_valid !== 1'b0) begin errors++; $display("FAIL short_no_output: got %0d vectors v=%0b, required 0", got_q.size() - b_out, m_valid); end
        fill_random(NF); exp = model_vec();
        send_frame(NF, NF - 1);
        checks++; if (m_data !== exp || m_valid !== 1'b1) begin errors++; $display("FAIL short_next: got %h v=%0b, required %h", m_data, m_valid, exp); end
    endtask

    task automatic test_long_frame();
        logic [NF-1:0] exp;
        int b_out, b_err;
        do_reset();
        m_ready = 1'b1;
        b_out = got_q.size();
        b_err = err_pulses;
        fill_random(41);
        send_frame(41, 40);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err_pulses - b_err != 1) begin errors++; $display("FAIL long_pulses: got %0d, required 1", err_pulses - b_err); end
        checks++; if (err_cnt !== sat(1)) begin errors++; $display("FAIL long_err_cnt: got %0d, required 1", err_cnt); end
        checks++; if (got_q.size() != b_out || m_valid !== 1'b0) begin errors++; $display("FAIL long_no_output: got %0d vectors v=%0b, required 0", got_q.size() - b_out, m_valid); end
        fill_random(NF); exp = model_vec();
        send_frame(NF, NF - 1);
        checks++; if (m_data !== exp || m_valid !== 1'b1) begin errors++; $display("FAIL long_next: got %h v=%0b, required %h", m_data, m_valid, exp); end
    endtask

    task automatic test_reset_hold();
        logic [NF-1:0] exp;
        int base;
        do_reset();
        cfg_write(0, 10);
        m_ready = 1'b0;
        fill_random(NF); send_frame(NF, NF - 1);
        fill_random(NF); send_frame(NF, NF - 1);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rh_in_hold: s_ready=%0b, required 0", s_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== '0) begin errors++; $display("FAIL rh_async_out: v=%0b data=%h, required 0", m_valid, m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rh_async_ready: got %0b, required 1", s_ready); end
        checks++; if (frame_cnt !== '0 || err_cnt !== '0) begin errors++; $display("FAIL rh_async_cnt: frames=%0d errs=%0d, required 0", frame_cnt, err_cnt); end
        for (int i = 0; i < NF; i++) mthr[i] = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        base = got_q.size();
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (got_q.size() != base || m_valid !== 1'b0) begin errors++; $display("FAIL rh_stale: got %0d vectors v=%0b, required 0", got_q.size() - base, m_valid); end
        for (int i = 0; i < NF; i++) fbuf[i] = '0;
        exp = model_vec();
        send_frame(NF, NF - 1);
        checks++; if (m_data !== exp || m_valid !== 1'b1) begin errors++; $display("FAIL rh_thr_cleared: got %h v=%0b, required %h", m_data, m_valid, exp); end
    endtask

    task automatic test_saturation();
        int b_err;
        do_reset();
        m_ready = 1'b1;
        b_err = err_pulses;
        fbuf[0] = '0;
        for (int k = 0; k < 9; k++) send_frame(1, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (err_pulses - b_err != 9) begin errors++; $display("FAIL sat_pulses: got %0d, required 9", err_pulses - b_err); end
        checks++; if (err_cnt !== sat(9)) begin errors++; $display("FAIL sat_err_cnt: got %0d, required %0d", err_cnt, sat(9)); end
        for (int k = 0; k < 9; k++) begin
            fill_random(NF);
            send_frame(NF, NF - 1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (frame_cnt !== sat(9)) begin errors++; $display("FAIL sat_frame_cnt: got %0d, required %0d", frame_cnt, sat(9)); end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_threshold();
        test_random();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_reset_hold();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
